// File: rtl/screen_to_origin_scan.sv
// Raster-order scan of a screen-pixel rectangle emitting origin-centred Q11.5 X/Y per pixel.
// Start comes from the bounding-box unit; pixels leave on a valid/ready stream.
module screen_to_origin_scan #(
    parameter int unsigned SCR_W = 640,
    parameter int unsigned SCR_H = 480,
    parameter int unsigned FRAC  = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [$clog2(SCR_W)-1:0]   rect_x0,
    input  logic [$clog2(SCR_H)-1:0]   rect_y0,
    input  logic [$clog2(SCR_W)-1:0]   rect_x1,
    input  logic [$clog2(SCR_H)-1:0]   rect_y1,
    output logic                       busy,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [15:0]                out_X,
    output logic [15:0]                out_Y,
    output logic                       out_last,
    output logic                       done
);

    localparam int unsigned XW = $clog2(SCR_W);
    localparam int unsigned YW = $clog2(SCR_H);
    localparam int unsigned CW = 16;
    localparam logic [CW-1:0] X_OFF = CW'((SCR_W / 2) << FRAC);
    localparam logic [CW-1:0] Y_OFF = CW'((SCR_H / 2) << FRAC);
    localparam logic [XW-1:0] X_MAX = XW'(SCR_W - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(SCR_H - 1);

    typedef enum logic [1:0] {IDLE, SCAN, FINISH} state_t;

    state_t        state, state_nxt;
    logic [XW-1:0] px, x0, x1, px_nxt, x0_nxt, x1_nxt;
    logic [YW-1:0] py, y0, y1, py_nxt, y0_nxt, y1_nxt;
    logic [XW-1:0] cx0_c, cx1_c;
    logic [YW-1:0] cy0_c, cy1_c;
    logic          hs_c;

    logic          busy_nxt, valid_nxt, last_nxt, done_nxt;
    logic [CW-1:0] x_nxt, y_nxt;

    assign cx0_c = (rect_x0 > X_MAX) ? X_MAX : rect_x0;
    assign cx1_c = (rect_x1 > X_MAX) ? X_MAX : rect_x1;
    assign cy0_c = (rect_y0 > Y_MAX) ? Y_MAX : rect_y0;
    assign cy1_c = (rect_y1 > Y_MAX) ? Y_MAX : rect_y1;
    assign hs_c  = out_valid && out_ready;

    // State, bounds, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            px        <= '0;
            py        <= '0;
            x0        <= '0;
            x1        <= '0;
            y0        <= '0;
            y1        <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b0;
            out_X     <= '0;
            out_Y     <= '0;
        end else begin
            state     <= state_nxt;
            px        <= px_nxt;
            py        <= py_nxt;
            x0        <= x0_nxt;
            x1        <= x1_nxt;
            y0        <= y0_nxt;
            y1        <= y1_nxt;
            busy      <= busy_nxt;
            out_valid <= valid_nxt;
            out_last  <= last_nxt;
            done      <= done_nxt;
            out_X     <= x_nxt;
            out_Y     <= y_nxt;
        end
    end

    // Next state and counter advance; start only honoured in IDLE
    always_comb begin
        state_nxt = state;
        px_nxt    = px;
        py_nxt    = py;
        x0_nxt    = x0;
        x1_nxt    = x1;
        y0_nxt    = y0;
        y1_nxt    = y1;
        case (state)
            IDLE: begin
                if (start) begin
                    x0_nxt    = cx0_c;
                    x1_nxt    = cx1_c;
                    y0_nxt    = cy0_c;
                    y1_nxt    = cy1_c;
                    px_nxt    = cx0_c;
                    py_nxt    = cy0_c;
                    state_nxt = ((cx0_c > cx1_c) || (cy0_c > cy1_c)) ? FINISH : SCAN;
                end
            end
            SCAN: begin
                if (hs_c) begin
                    if (px < x1) begin
                        px_nxt = px + XW'(1);
                    end else begin
                        px_nxt = x0;
                        if (py < y1) begin
                            py_nxt = py + YW'(1);
                        end else begin
                            state_nxt = FINISH;
                        end
                    end
                end
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output values loaded into the output registers on the next edge
    always_comb begin
        busy_nxt  = (state_nxt == SCAN);
        valid_nxt = (state_nxt == SCAN);
        done_nxt  = (state_nxt == FINISH);
        last_nxt  = (state_nxt == SCAN) && (px_nxt == x1_nxt) && (py_nxt == y1_nxt);
        x_nxt     = (CW'(px_nxt) << FRAC) - X_OFF;
        y_nxt     = (CW'(py_nxt) << FRAC) - Y_OFF;
    end

endmodule

// File: tb/tb_screen_to_origin_scan.sv
// Bench for screen_to_origin_scan: directed table, random rectangles vs. a loop-based pixel model,
// plus reset-abort and start-while-busy sequences.
module tb_screen_to_origin_scan;

    localparam int SCR_W = 640;
    localparam int SCR_H = 480;
    localparam int FRAC  = 5;
    localparam int BUDGET = 4000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  rect_x0, rect_x1;
    logic [8:0]  rect_y0, rect_y1;
    logic        busy, out_valid, out_ready, out_last, done;
    logic [15:0] out_X, out_Y;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic        last;
    } beat_t;

    typedef struct {
        int          x0, y0, x1, y1;
        int          mode;      // 0 ready=1, 1 toggle 0/1, 2 random
        int          restart;   // cycle index of an extra start, -1 none
        int          n;
        logic [15:0] fx, fy, lx, ly;
    } vec_t;

    vec_t tbl[7];

    screen_to_origin_scan #(.SCR_W(SCR_W), .SCR_H(SCR_H), .FRAC(FRAC)) dut (
        .clk(clk), .rst(rst), .start(start),
        .rect_x0(rect_x0), .rect_y0(rect_y0), .rect_x1(rect_x1), .rect_y1(rect_y1),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_X(out_X), .out_Y(out_Y), .out_last(out_last), .done(done)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endfunction

    function automatic logic [15:0] centred(input int p, input int half);
        int v;
        v = p * (1 << FRAC) - half * (1 << FRAC);
        return 16'(v);
    endfunction

    // Runs one scan from posedge+1; returns beat count and first/last accepted coordinates.
    task automatic run_scan(input int x0, input int y0, input int x1, input int y1,
                            input int mode, input int restart,
                            output int nb, output logic [15:0] fx, output logic [15:0] fy,
                            output logic [15:0] lx, output logic [15:0] ly);
        beat_t q[$];
        beat_t b;
        logic [9:0] tx0, tx1;
        logic [8:0] ty0, ty1;
        int cx0, cx1, cy0, cy1, exp_n;
        bit seen_done;
        tx0 = 10'(x0); tx1 = 10'(x1); ty0 = 9'(y0); ty1 = 9'(y1);
        cx0 = (int'(tx0) > SCR_W - 1) ? SCR_W - 1 : int'(tx0);
        cx1 = (int'(tx1) > SCR_W - 1) ? SCR_W - 1 : int'(tx1);
        cy0 = (int'(ty0) > SCR_H - 1) ? SCR_H - 1 : int'(ty0);
        cy1 = (int'(ty1) > SCR_H - 1) ? SCR_H - 1 : int'(ty1);
        for (int yy = cy0; yy <= cy1; yy++)
            for (int xx = cx0; xx <= cx1; xx++) begin
                b.x = centred(xx, SCR_W / 2);
                b.y = centred(yy, SCR_H / 2);
                b.last = (xx == cx1) && (yy == cy1);
                q.push_back(b);
            end
        exp_n = q.size();
        nb = 0; fx = '0; fy = '0; lx = '0; ly = '0;
        seen_done = 0;

        rect_x0 = tx0; rect_x1 = tx1; rect_y0 = ty0; rect_y1 = ty1;
        start = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        if (exp_n == 0) chk("empty_done_latency", 32'(done), 32'd1);
        else            chk("first_valid_latency", 32'(out_valid), 32'd1);

        for (int cyc = 0; cyc < BUDGET; cyc++) begin
            start = 1'b0;
            if (cyc == restart) begin
                rect_x0 = 10'd100; rect_y0 = 9'd100; rect_x1 = 10'd101; rect_y1 = 9'd101;
                start = 1'b1;
            end
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 2) == 1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (done) begin
                chk("done_busy_low", 32'(busy), 32'd0);
                chk("done_valid_low", 32'(out_valid), 32'd0);
                chk("done_all_beats", 32'(q.size()), 32'd0);
                seen_done = 1;
                break;
            end
            if (out_valid) begin
                chk("valid_busy", 32'(busy), 32'd1);
                if (q.size() == 0) begin
                    chk("extra_beat", 32'(out_valid), 32'd0);
                end else begin
                    chk("beat_x", 32'(out_X), 32'(q[0].x));
                    chk("beat_y", 32'(out_Y), 32'(q[0].y));
                    chk("beat_last", 32'(out_last), 32'(q[0].last));
                    if (out_ready) begin
                        if (nb == 0) begin fx = out_X; fy = out_Y; end
                        lx = out_X; ly = out_Y;
                        nb++;
                        void'(q.pop_front());
                    end
                end
            end
            @(posedge clk); #1;
        end
        if (!seen_done) chk("done_timeout", 32'd0, 32'd1);
        // A start landing on the done cycle must be ignored
        rect_x0 = 10'd1; rect_y0 = 9'd1; rect_x1 = 10'd1; rect_y1 = 9'd1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("idle_after_done", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk("start_in_finish_ignored", 32'(busy | out_valid | done), 32'd0);
        chk("beat_count", 32'(nb), 32'(exp_n));
        out_ready = 1'b0;
    endtask

    initial begin
        int nb, hs, quiet_done;
        logic [15:0] fx, fy, lx, ly;

        tbl[0] = '{320, 240, 320, 240, 0, -1, 1,  16'h0000, 16'h0000, 16'h0000, 16'h0000};
        tbl[1] = '{0,   0,   1,   1,   0, -1, 4,  16'hD800, 16'hE200, 16'hD820, 16'hE220};
        tbl[2] = '{10,  5,   12,  5,   1, -1, 3,  16'hD940, 16'hE2A0, 16'hD980, 16'hE2A0};
        tbl[3] = '{700, 0,   800, 0,   0, -1, 1,  16'h27E0, 16'hE200, 16'h27E0, 16'hE200};
        tbl[4] = '{5,   0,   4,   0,   0, -1, 0,  16'h0000, 16'h0000, 16'h0000, 16'h0000};
        tbl[5] = '{1023, 511, 1023, 511, 0, -1, 1, 16'h27E0, 16'h1DE0, 16'h27E0, 16'h1DE0};
        tbl[6] = '{0,   0,   3,   3,   2, 5,  16, 16'hD800, 16'hE200, 16'hD860, 16'hE260};

        rst = 1'b1; start = 1'b0; out_ready = 1'b0;
        rect_x0 = '0; rect_y0 = '0; rect_x1 = '0; rect_y1 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_x", 32'(out_X), 32'd0);
        chk("rst_y", 32'(out_Y), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (tbl[i]) begin
            run_scan(tbl[i].x0, tbl[i].y0, tbl[i].x1, tbl[i].y1, tbl[i].mode, tbl[i].restart,
                     nb, fx, fy, lx, ly);
            chk($sformatf("tbl%0d_count", i), 32'(nb), 32'(tbl[i].n));
            if (tbl[i].n > 0) begin
                chk($sformatf("tbl%0d_first_x", i), 32'(fx), 32'(tbl[i].fx));
                chk($sformatf("tbl%0d_first_y", i), 32'(fy), 32'(tbl[i].fy));
                chk($sformatf("tbl%0d_last_x", i), 32'(lx), 32'(tbl[i].lx));
                chk($sformatf("tbl%0d_last_y", i), 32'(ly), 32'(tbl[i].ly));
            end
        end

        for (int r = 0; r < 25; r++) begin
            int ax0, ay0, ax1, ay1;
            ax0 = $urandom_range(0, 660);
            ay0 = $urandom_range(0, 500);
            ax1 = ax0 + $urandom_range(0, 4);
            ay1 = ay0 + $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0 && ax0 >= 6) ax1 = ax0 - 6;
            run_scan(ax0, ay0, ax1, ay1, $urandom_range(0, 2), -1, nb, fx, fy, lx, ly);
        end

        // Reset after the third accepted beat of a 4x4 scan
        rect_x0 = 10'd0; rect_y0 = 9'd0; rect_x1 = 10'd3; rect_y1 = 9'd3;
        start = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        hs = 0;
        for (int cyc = 0; cyc < 20 && hs < 3; cyc++) begin
            if (out_valid && out_ready) hs++;
            @(posedge clk); #1;
        end
        chk("abort_three_beats", 32'(hs), 32'd3);
        chk("abort_pre_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        quiet_done = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (done || out_valid) quiet_done++;
            @(posedge clk); #1;
        end
        chk("abort_no_done", 32'(quiet_done), 32'd0);
        run_scan(320, 240, 320, 240, 0, -1, nb, fx, fy, lx, ly);
        chk("post_abort_count", 32'(nb), 32'd1);
        chk("post_abort_x", 32'(fx), 32'h0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
